// File: rtl/draw_ball.sv
// ---------------------------------------------------------------------------
// draw_ball
// Redraws a square ball of BALL_SIZE x BALL_SIZE pixels on a VGA frame
// buffer. When a new ball position is announced, the ball at the previously
// drawn position is first erased with BG_COLOUR, then drawn at the new
// position with BALL_COLOUR, one pixel per enabled clock cycle.
//
// Ports
//   clock       : single clock, all state on its rising edge
//   resetn      : asynchronous active-low reset
//   enable      : when low, FSM/offsets/drawDone hold and plot is forced low
//   ballSolved  : one-cycle pulse, xBallIn/yBallIn hold a new position
//   xBallIn     : new ball top-left column (8 bits)
//   yBallIn     : new ball top-left row (7 bits)
//   x, y        : registered pixel address to the VGA adapter
//   colour      : registered pixel colour
//   plot        : registered write strobe for (x, y, colour)
//   drawDone    : one-cycle pulse when a full redraw completes
//   busy        : high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module draw_ball #(
    parameter int unsigned BALL_SIZE   = 2,
    parameter logic [2:0]  BALL_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR   = 3'b000,
    parameter int unsigned X_MAX       = 159,
    parameter int unsigned Y_MAX       = 119
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic       ballSolved,
    input  logic [7:0] xBallIn,
    input  logic [6:0] yBallIn,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       drawDone,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Offsets run 0..BALL_SIZE-1, BALL_SIZE is at most 4.
    localparam logic [1:0] OFF_LAST = 2'(BALL_SIZE - 1);
    // Visibility limits at the widened pixel-address width.
    localparam logic [8:0] X_LIM    = 9'(X_MAX);
    localparam logic [7:0] Y_LIM    = 8'(Y_MAX);

    logic [1:0] state_q,     state_d;
    logic [1:0] dx_q,        dx_d;
    logic [1:0] dy_q,        dy_d;
    logic [7:0] new_x_q,     new_x_d;
    logic [6:0] new_y_q,     new_y_d;
    logic [7:0] old_x_q,     old_x_d;
    logic [6:0] old_y_q,     old_y_d;
    logic       has_drawn_q, has_drawn_d;
    logic       pend_q,      pend_d;
    logic [7:0] pend_x_q,    pend_x_d;
    logic [6:0] pend_y_q,    pend_y_d;
    logic [7:0] x_q,         x_d;
    logic [6:0] y_q,         y_d;
    logic [2:0] colour_q,    colour_d;
    logic       plot_q,      plot_d;
    logic       done_q,      done_d;
    logic       busy_q,      busy_d;

    logic [7:0] base_x_s;
    logic [6:0] base_y_s;
    logic [8:0] px_s;
    logic [7:0] py_s;
    logic       last_s;
    logic       start_s;

    // Next-state logic: FSM, offset stepping, position bookkeeping and outputs.
    always_comb begin
        state_d     = state_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        has_drawn_d = has_drawn_q;
        pend_d      = pend_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        x_d         = x_q;
        y_d         = y_q;
        colour_d    = colour_q;
        plot_d      = 1'b0;
        done_d      = done_q;
        start_s     = 1'b0;

        // ERASE walks the old square, every other state the new one.
        if (state_q == S_ERASE) begin
            base_x_s = old_x_q;
            base_y_s = old_y_q;
        end else begin
            base_x_s = new_x_q;
            base_y_s = new_y_q;
        end
        // Widened so a square hanging off the right/bottom edge never wraps.
        px_s   = {1'b0, base_x_s} + {7'd0, dx_q};
        py_s   = {1'b0, base_y_s} + {6'd0, dy_q};
        last_s = (dx_q == OFF_LAST) && (dy_q == OFF_LAST);

        // Any request that cannot start right now is parked; newest wins.
        if (ballSolved && !((state_q == S_IDLE) && enable)) begin
            pend_d   = 1'b1;
            pend_x_d = xBallIn;
            pend_y_d = yBallIn;
        end else begin
            pend_d   = pend_d;
        end

        if (enable) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ballSolved) begin
                        new_x_d = xBallIn;
                        new_y_d = yBallIn;
                        pend_d  = 1'b0;
                        start_s = 1'b1;
                    end else if (pend_q) begin
                        new_x_d = pend_x_q;
                        new_y_d = pend_y_q;
                        pend_d  = 1'b0;
                        start_s = 1'b1;
                    end else begin
                        start_s = 1'b0;
                    end
                    if (start_s) begin
                        dx_d    = 2'd0;
                        dy_d    = 2'd0;
                        state_d = has_drawn_q ? S_ERASE : S_DRAW;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ERASE, S_DRAW: begin
                    x_d      = px_s[7:0];
                    y_d      = py_s[6:0];
                    colour_d = (state_q == S_ERASE) ? BG_COLOUR : BALL_COLOUR;
                    plot_d   = (px_s <= X_LIM) && (py_s <= Y_LIM);
                    // dx is the fast index, dy advances when dx wraps.
                    if (dx_q == OFF_LAST) begin
                        dx_d = 2'd0;
                        dy_d = dy_q + 2'd1;
                    end else begin
                        dx_d = dx_q + 2'd1;
                    end
                    if (last_s) begin
                        dy_d    = 2'd0;
                        state_d = (state_q == S_ERASE) ? S_DRAW : S_DONE;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_DONE: begin
                    done_d      = 1'b1;
                    old_x_d     = new_x_q;
                    old_y_d     = new_y_q;
                    has_drawn_d = 1'b1;
                    state_d     = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            dx_q        <= 2'd0;
            dy_q        <= 2'd0;
            new_x_q     <= 8'd0;
            new_y_q     <= 7'd0;
            old_x_q     <= 8'd0;
            old_y_q     <= 7'd0;
            has_drawn_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_x_q    <= 8'd0;
            pend_y_q    <= 7'd0;
            x_q         <= 8'd0;
            y_q         <= 7'd0;
            colour_q    <= 3'd0;
            plot_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            new_x_q     <= new_x_d;
            new_y_q     <= new_y_d;
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            has_drawn_q <= has_drawn_d;
            pend_q      <= pend_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            plot_q      <= plot_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign colour   = colour_q;
    assign plot     = plot_q;
    assign drawDone = done_q;
    assign busy     = busy_q;

endmodule
